dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Sequencing controller for the single-port data memory (DMem) behind the MEM pipeline stage. It shares DMem between two requesters: the pipeline MEM stage (port P) and a debug/DMA requester (port D). Each access runs as a fixed multi-cycle transaction. While the pipeline's access is pending, the block stalls the pipeline, and it hands back read data with a one-cycle completion.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from DMem issue to valid m_rdata (≥1)
- STARVE_MAX, 4, consecutive P grants allowed while D waits (fairness build only)
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- p_req  input  1  MEM stage access request, held until completion
- p_we  input  1  1 = store, 0 = load
- p_addr  input  AW  MEM stage address (ALU output)
- p_wdata  input  DW  store data
- p_stall  output  1  freeze pipeline; combinational: p_req & ~(state==RESP & owner==P)
- p_rdata  output  DW  load data, valid while RESP & owner==P
- d_req  input  1  debug/DMA request, held until d_valid
- d_we  input  1  debug write enable
- d_addr  input  AW  debug address
- d_wdata  input  DW  debug write data
- d_valid  output  1  one-cycle completion pulse for D
- d_rdata  output  DW  debug read data, valid with d_valid
- m_re  output  1  DMem read strobe
- m_we  output  1  DMem write strobe
- m_addr  output  AW  DMem address
- m_wdata  output  DW  DMem write data
- m_rdata  input  DW  DMem read data, valid MEM_LAT cycles after issue

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: if p_req, grant P; else if d_req, grant D; else stay. On grant, latch owner, we, addr, and wdata. Later changes on the inputs are ignored.
- ISSUE (1 cycle): drive m_addr/m_wdata from the latches. Assert m_we if the access is a write, m_re otherwise. Strobes are low in every other state.
- WAIT: down-counter loaded with MEM_LAT−1. Capture m_rdata into the data register in the cycle the counter reaches 0, which is MEM_LAT cycles after ISSUE. Then go to RESP. With MEM_LAT=1, WAIT lasts one cycle.
- RESP (1 cycle): if owner==P, drop p_stall and present p_rdata. If owner==D, pulse d_valid with d_rdata. Next state is IDLE unconditionally, so there are no back-to-back grants.
- Writes use the same sequence and timing. Read-data outputs are don't-care for writes.
- Simultaneous p_req and d_req in IDLE: P wins, subject to Configuration.
- If a requester drops its request after the grant, the transaction still completes. The completion is discarded.
- If a requester drops its request before the grant, no access is made.
- p_rdata/d_rdata hold the last captured value outside RESP.

## Timing
- Reset (async assert, sync release): state IDLE, owner P, counters 0, m_re=m_we=0, m_addr=m_wdata=0, data register 0, d_valid=0. p_stall follows p_req combinationally.
- Reset mid-transaction: the transaction is abandoned and not retried. A write already issued may have landed.
- Latency: request visible in IDLE at cycle 0 → ISSUE cycle 1 → RESP cycle MEM_LAT+2. Total occupancy is MEM_LAT+3 cycles per access.
- The minimum gap between two consecutive ISSUE cycles is MEM_LAT+3.
- All outputs except p_stall are registered.

## Configuration
- Macro DMEM_ARB_FAIR_EN.
- Defined: a starvation counter increments on each P grant made while d_req is high. It clears on any D grant, and it clears when a P grant is made with d_req low. When the counter equals STARVE_MAX, the next IDLE arbitration grants D even if p_req is high.
- Undefined: strict P priority, and D may starve indefinitely. STARVE_MAX is unused.

## Structure
- Package dmem_arb_pkg holds:
  - arb_state_t enum (IDLE, ISSUE, WAIT, RESP)
  - owner_t enum (OWN_P, OWN_D)
  - default width localparams
- Sub-module dmem_arb_fair holds the starvation counter and the force-D output. It is instantiated only under DMEM_ARB_FAIR_EN.

## Test plan
- Load: MEM_LAT=1, p_req=1, p_we=0, p_addr=0x10, DMem[0x10]=0xDEADBEEF → m_re in cycle 1 only; p_stall high cycles 0–2, low cycle 3 with p_rdata=0xDEADBEEF.
- Store: p_we=1, p_addr=0x20, p_wdata=0x12345678 → m_we with m_addr=0x20 in cycle 1; a later debug read of 0x20 returns 0x12345678 with d_valid.
- Contention: p_req and d_req both high in IDLE → P served first. D is issued 4 cycles later (MEM_LAT=1) and d_valid pulses in cycle 7.
- Fairness with macro, STARVE_MAX=2: p_req held continuously and d_req high → sequence P, P, D, P. Without the macro → only P is served and d_valid never asserts.
- Reset mid-WAIT with MEM_LAT=3 → all strobes low immediately, state IDLE. After release with p_req still high, the access restarts and completes MEM_LAT+3 cycles later.
- Withdrawn request: p_req drops in the WAIT cycle → RESP occurs, p_stall stays low, and the next d_req is granted in the following IDLE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the DMem arbiter.
// Fairness build is enabled with `DMEM_ARB_FAIR_EN.
package dmem_arb_pkg;

   localparam int unsigned AW_DEF         = 32;
   localparam int unsigned DW_DEF         = 32;
   localparam int unsigned MEM_LAT_DEF    = 1;
   localparam int unsigned STARVE_MAX_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   typedef enum logic {
      OWN_P,
      OWN_D
   } owner_t;

endpackage

// File: rtl/dmem_arb_fair.sv
// Starvation counter for the debug port; raises force_d once the
// pipeline has won STARVE_MAX grants in a row while D was waiting.
module dmem_arb_fair
   import dmem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic grant_p,
   input  logic grant_d,
   input  logic d_req,
   output logic force_d
);

   localparam int unsigned SW = $clog2(STARVE_MAX + 1);

   logic [SW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (grant_d) begin
         cnt <= '0;
      end else if (grant_p) begin
         cnt <= d_req ? cnt + SW'(1) : '0;
      end
   end

   assign force_d = (cnt == SW'(STARVE_MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester sequencer for the single-port DMem behind MEM.
// Define DMEM_ARB_FAIR_EN to bound starvation of the debug port.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW         = AW_DEF,
   parameter int unsigned DW         = DW_DEF,
   parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          p_req,
   input  logic          p_we,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_wdata,
   output logic          p_stall,
   output logic [DW-1:0] p_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_valid,
   output logic [DW-1:0] d_rdata,
   output logic          m_re,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata
);

   localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

   if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_param_check
      $error("dmem_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
   end

   arb_state_t    state;
   arb_state_t    state_nxt;
   owner_t        owner;
   logic          we_q;
   logic [CW-1:0] cnt;
   logic [DW-1:0] data_q;
   logic          grant_p;
   logic          grant_d;
   logic          force_d;

`ifdef DMEM_ARB_FAIR_EN
   dmem_arb_fair #(
      .STARVE_MAX (STARVE_MAX)
   ) u_fair (
      .clk     (clk),
      .reset   (reset),
      .grant_p (grant_p),
      .grant_d (grant_d),
      .d_req   (d_req),
      .force_d (force_d)
   );
`else
   assign force_d = 1'b0;
`endif

   assign grant_d = (state == IDLE) & d_req & (~p_req | force_d);
   assign grant_p = (state == IDLE) & p_req & ~grant_d;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (grant_p | grant_d) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         owner   <= OWN_P;
         we_q    <= 1'b0;
         cnt     <= '0;
         data_q  <= '0;
         m_re    <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
         d_valid <= 1'b0;
      end else begin
         state   <= state_nxt;
         m_re    <= 1'b0;
         m_we    <= 1'b0;
         d_valid <= 1'b0;
         // strobes are set on grant so they are high exactly in ISSUE
         if (grant_p) begin
            owner   <= OWN_P;
            we_q    <= p_we;
            m_addr  <= p_addr;
            m_wdata <= p_wdata;
            m_re    <= ~p_we;
            m_we    <= p_we;
         end else if (grant_d) begin
            owner   <= OWN_D;
            we_q    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
            m_re    <= ~d_we;
            m_we    <= d_we;
         end
         if (state == ISSUE) begin
            cnt <= CNT_LOAD;
         end
         if (state == WAIT) begin
            if (cnt == '0) begin
               if (!we_q) data_q <= m_rdata;
               d_valid <= (owner == OWN_D);
            end else begin
               cnt <= cnt - CW'(1);
            end
         end
      end
   end

   assign p_stall = p_req & ~((state == RESP) & (owner == OWN_P));
   assign p_rdata = data_q;
   assign d_rdata = data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed table, corner
// sequences and a randomized run against a timeline model.
module tb_dmem_arbiter;

   localparam int LAT_A = 1;
   localparam int LAT_B = 3;
   localparam int SMAX  = 2;
   localparam logic [31:0] JUNK = 32'h0BAD_F00D;

   typedef struct {
      bit          own_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_a;
   logic reset_b;

   logic        a_p_req, a_p_we, a_p_stall;
   logic [31:0] a_p_addr, a_p_wdata, a_p_rdata;
   logic        a_d_req, a_d_we, a_d_valid;
   logic [31:0] a_d_addr, a_d_wdata, a_d_rdata;
   logic        a_m_re, a_m_we;
   logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;

   logic        b_p_req, b_p_we, b_p_stall;
   logic [31:0] b_p_addr, b_p_wdata, b_p_rdata;
   logic        b_d_req, b_d_we, b_d_valid;
   logic [31:0] b_d_addr, b_d_wdata, b_d_rdata;
   logic        b_m_re, b_m_we;
   logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;
   logic [31:0] b_s1, b_s2;

   logic [31:0] mem_a [16];
   logic [31:0] mem_b [16];
   logic [31:0] ref_mem [16];

   int checks = 0;
   int errors = 0;

   dmem_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(LAT_A), .STARVE_MAX(SMAX)
   ) dut_a (
      .clk(clk), .reset(reset_a),
      .p_req(a_p_req), .p_we(a_p_we), .p_addr(a_p_addr),
      .p_wdata(a_p_wdata), .p_stall(a_p_stall), .p_rdata(a_p_rdata),
      .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr),
      .d_wdata(a_d_wdata), .d_valid(a_d_valid), .d_rdata(a_d_rdata),
      .m_re(a_m_re), .m_we(a_m_we), .m_addr(a_m_addr),
      .m_wdata(a_m_wdata), .m_rdata(a_m_rdata)
   );

   dmem_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(LAT_B), .STARVE_MAX(4)
   ) dut_b (
      .clk(clk), .reset(reset_b),
      .p_req(b_p_req), .p_we(b_p_we), .p_addr(b_p_addr),
      .p_wdata(b_p_wdata), .p_stall(b_p_stall), .p_rdata(b_p_rdata),
      .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr),
      .d_wdata(b_d_wdata), .d_valid(b_d_valid), .d_rdata(b_d_rdata),
      .m_re(b_m_re), .m_we(b_m_we), .m_addr(b_m_addr),
      .m_wdata(b_m_wdata), .m_rdata(b_m_rdata)
   );

   // DMem models: data valid exactly MEM_LAT cycles after the read strobe
   always @(posedge clk) begin
      if (a_m_we) mem_a[a_m_addr[5:2]] <= a_m_wdata;
      a_m_rdata <= a_m_re ? mem_a[a_m_addr[5:2]] : JUNK;
   end

   always @(posedge clk) begin
      if (b_m_we) mem_b[b_m_addr[5:2]] <= b_m_wdata;
      b_s1      <= b_m_re ? mem_b[b_m_addr[5:2]] : JUNK;
      b_s2      <= b_s1;
      b_m_rdata <= b_s2;
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] raddr();
      logic [3:0] w;
      w = 4'($urandom_range(0, 15));
      return {26'd0, w, 2'b00};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      int rk;
      rk = LAT_A + 2;
      if (v.own_d) begin
         a_d_req = 1'b1; a_d_we = v.we; a_d_addr = v.addr; a_d_wdata = v.wdata;
      end else begin
         a_p_req = 1'b1; a_p_we = v.we; a_p_addr = v.addr; a_p_wdata = v.wdata;
      end
      for (int k = 0; k <= rk; k++) begin
         @(negedge clk);
         chk1("vec_m_re", a_m_re, k == 1 && !v.we);
         chk1("vec_m_we", a_m_we, k == 1 && v.we);
         if (k == 1) chk32("vec_m_addr", a_m_addr, v.addr);
         if (k == 1 && v.we) chk32("vec_m_wdata", a_m_wdata, v.wdata);
         chk1("vec_p_stall", a_p_stall, !v.own_d && k != rk);
         chk1("vec_d_valid", a_d_valid, v.own_d && k == rk);
         if (k == rk && !v.we)
            chk32("vec_rdata", v.own_d ? a_d_rdata : a_p_rdata, v.exp_rdata);
         next_cycle();
         if (k == rk) begin
            a_p_req = 1'b0;
            a_d_req = 1'b0;
         end else if (v.own_d) begin
            a_d_addr = $urandom; a_d_wdata = $urandom; a_d_we = 1'($urandom);
         end else begin
            a_p_addr = $urandom; a_p_wdata = $urandom; a_p_we = 1'($urandom);
         end
      end
   endtask

   vec_t vecs[6];
   bit   own_exp[4];

   int          c, free_at, t0, starve;
   bit          busy, own_d, twe, force_m, gd, issue, resp, p_done, d_done;
   logic [31:0] taddr, twdata, texp;

   initial begin
      vecs[0] = '{own_d:0, we:0, addr:32'h10, wdata:32'h0, exp_rdata:32'hDEADBEEF};
      vecs[1] = '{own_d:0, we:1, addr:32'h20, wdata:32'h12345678, exp_rdata:32'h0};
      vecs[2] = '{own_d:1, we:0, addr:32'h20, wdata:32'h0, exp_rdata:32'h12345678};
      vecs[3] = '{own_d:1, we:1, addr:32'h30, wdata:32'hCAFEF00D, exp_rdata:32'h0};
      vecs[4] = '{own_d:0, we:0, addr:32'h30, wdata:32'h0, exp_rdata:32'hCAFEF00D};
      vecs[5] = '{own_d:1, we:0, addr:32'h10, wdata:32'h0, exp_rdata:32'hDEADBEEF};

      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 32'hA5A5_0000 | 32'(i);
         mem_b[i] = 32'h5A5A_0000 | 32'(i);
      end
      mem_a[4] = 32'hDEADBEEF;
      mem_b[4] = 32'hDEADBEEF;

      reset_a = 1'b0; reset_b = 1'b0;
      a_p_req = 0; a_p_we = 0; a_p_addr = 0; a_p_wdata = 0;
      a_d_req = 0; a_d_we = 0; a_d_addr = 0; a_d_wdata = 0;
      b_p_req = 0; b_p_we = 0; b_p_addr = 0; b_p_wdata = 0;
      b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk1("rst_m_re", a_m_re, 1'b0);
      chk1("rst_m_we", a_m_we, 1'b0);
      chk32("rst_m_addr", a_m_addr, 32'h0);
      chk32("rst_m_wdata", a_m_wdata, 32'h0);
      chk1("rst_d_valid", a_d_valid, 1'b0);
      chk32("rst_p_rdata", a_p_rdata, 32'h0);
      chk32("rst_d_rdata", a_d_rdata, 32'h0);
      chk1("rst_p_stall_lo", a_p_stall, 1'b0);
      a_p_req = 1'b1;
      #1;
      chk1("rst_p_stall_hi", a_p_stall, 1'b1);
      a_p_req = 1'b0;
      next_cycle();
      reset_a = 1'b1;
      reset_b = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // contention: P first, D issued four cycles later
      a_p_req = 1; a_p_we = 0; a_p_addr = 32'h10;
      a_d_req = 1; a_d_we = 0; a_d_addr = 32'h20;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         chk1("cont_m_re", a_m_re, k == 1 || k == 5);
         if (k == 1) chk32("cont_addr_p", a_m_addr, 32'h10);
         if (k == 5) chk32("cont_addr_d", a_m_addr, 32'h20);
         chk1("cont_p_stall", a_p_stall, k < 3);
         chk1("cont_d_valid", a_d_valid, k == 7);
         if (k == 3) chk32("cont_p_rdata", a_p_rdata, 32'hDEADBEEF);
         if (k == 7) chk32("cont_d_rdata", a_d_rdata, 32'h12345678);
         next_cycle();
         if (k == 3) a_p_req = 0;
         if (k == 7) a_d_req = 0;
      end

      // fairness: both held, P re-requests continuously
`ifdef DMEM_ARB_FAIR_EN
      own_exp = '{0, 0, 1, 0};
`else
      own_exp = '{0, 0, 0, 0};
`endif
      a_p_req = 1; a_p_we = 0; a_p_addr = 32'h10;
      a_d_req = 1; a_d_we = 0; a_d_addr = 32'h20;
      for (int k = 0; k < 16; k++) begin
         int s, ph;
         s = k / 4;
         ph = k % 4;
         @(negedge clk);
         chk1("fair_m_re", a_m_re, ph == 1);
         if (ph == 1)
            chk32("fair_owner_addr", a_m_addr, own_exp[s] ? 32'h20 : 32'h10);
         chk1("fair_d_valid", a_d_valid, own_exp[s] && ph == 3);
         chk1("fair_p_stall", a_p_stall, !(ph == 3 && !own_exp[s]));
         next_cycle();
         if (own_exp[s] && ph == 3) a_d_req = 0;
         if (k == 15) begin
            a_p_req = 0;
            a_d_req = 0;
         end
      end

      // withdrawn request: P drops in WAIT, D then served
      a_p_req = 1; a_p_we = 0; a_p_addr = 32'h30;
      for (int k = 0; k <= 7; k++) begin
         @(negedge clk);
         chk1("wd_m_re", a_m_re, k == 1 || k == 5);
         if (k == 5) chk32("wd_addr", a_m_addr, 32'h10);
         chk1("wd_p_stall", a_p_stall, k < 2);
         chk1("wd_d_valid", a_d_valid, k == 7);
         if (k == 7) chk32("wd_d_rdata", a_d_rdata, 32'hDEADBEEF);
         next_cycle();
         if (k == 1) begin
            a_p_req = 0;
            a_d_req = 1; a_d_we = 0; a_d_addr = 32'h10;
         end
         if (k == 7) a_d_req = 0;
      end

      // reset in the middle of WAIT with MEM_LAT=3
      b_p_req = 1; b_p_we = 0; b_p_addr = 32'h10;
      for (int k = 0; k <= 2; k++) begin
         @(negedge clk);
         chk1("rw_pre_m_re", b_m_re, k == 1);
         next_cycle();
      end
      #2 reset_b = 1'b0;
      #1;
      chk1("rw_m_re", b_m_re, 1'b0);
      chk1("rw_m_we", b_m_we, 1'b0);
      chk32("rw_m_addr", b_m_addr, 32'h0);
      chk1("rw_d_valid", b_d_valid, 1'b0);
      chk1("rw_p_stall", b_p_stall, 1'b1);
      chk32("rw_rdata", b_p_rdata, 32'h0);
      next_cycle();
      reset_b = 1'b1;
      for (int k = 0; k <= LAT_B + 2; k++) begin
         @(negedge clk);
         chk1("rs_m_re", b_m_re, k == 1);
         if (k == 1) chk32("rs_addr", b_m_addr, 32'h10);
         chk1("rs_p_stall", b_p_stall, k != LAT_B + 2);
         chk1("rs_d_valid", b_d_valid, 1'b0);
         if (k == LAT_B + 2) begin
            chk32("rs_p_rdata", b_p_rdata, 32'hDEADBEEF);
            chk32("rs_d_rdata", b_d_rdata, 32'hDEADBEEF);
         end
         next_cycle();
         if (k == LAT_B + 2) b_p_req = 0;
      end

      // randomized traffic against a transaction timeline model
      reset_a = 1'b0;
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = $urandom;
         ref_mem[i] = mem_a[i];
      end
      next_cycle();
      reset_a = 1'b1;
      free_at = 0; t0 = 0; starve = 0; busy = 0;
      own_d = 0; twe = 0; taddr = 0; twdata = 0; texp = 0;
      for (c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (c >= free_at && (a_p_req || a_d_req)) begin
`ifdef DMEM_ARB_FAIR_EN
            force_m = (starve == SMAX);
`else
            force_m = 1'b0;
`endif
            gd = a_d_req && (!a_p_req || force_m);
            own_d  = gd;
            twe    = gd ? a_d_we : a_p_we;
            taddr  = gd ? a_d_addr : a_p_addr;
            twdata = gd ? a_d_wdata : a_p_wdata;
            t0 = c;
            free_at = c + LAT_A + 3;
            busy = 1;
            if (gd || !a_d_req) starve = 0;
            else starve++;
         end
         issue = busy && c == t0 + 1;
         resp  = busy && c == t0 + LAT_A + 2;
         if (issue) begin
            if (twe) ref_mem[taddr[5:2]] = twdata;
            else texp = ref_mem[taddr[5:2]];
         end
         chk1("rnd_m_re", a_m_re, issue && !twe);
         chk1("rnd_m_we", a_m_we, issue && twe);
         if (issue) chk32("rnd_m_addr", a_m_addr, taddr);
         if (issue && twe) chk32("rnd_m_wdata", a_m_wdata, twdata);
         chk1("rnd_p_stall", a_p_stall, a_p_req && !(resp && !own_d));
         chk1("rnd_d_valid", a_d_valid, resp && own_d);
         if (resp && !twe)
            chk32("rnd_rdata", own_d ? a_d_rdata : a_p_rdata, texp);
         p_done = resp && !own_d;
         d_done = resp && own_d;
         next_cycle();
         if (a_p_req) begin
            if (p_done || $urandom_range(0, 31) == 0) a_p_req = 0;
            else if ($urandom_range(0, 3) == 0) begin
               a_p_addr = raddr(); a_p_wdata = $urandom; a_p_we = 1'($urandom);
            end
         end else if ($urandom_range(0, 2) == 0) begin
            a_p_req = 1; a_p_addr = raddr(); a_p_wdata = $urandom;
            a_p_we = 1'($urandom);
         end
         if (a_d_req) begin
            if (d_done || $urandom_range(0, 31) == 0) a_d_req = 0;
            else if ($urandom_range(0, 3) == 0) begin
               a_d_addr = raddr(); a_d_wdata = $urandom; a_d_we = 1'($urandom);
            end
         end else if ($urandom_range(0, 3) == 0) begin
            a_d_req = 1; a_d_addr = raddr(); a_d_wdata = $urandom;
            a_d_we = 1'($urandom);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
